// File: rtl/easy_driver_axis_ctrl_pkg.sv
// Shared types and default constants for the EasyDriver single-axis sequencer.
package easy_driver_axis_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STEP_HI = 3'd2,
        STEP_LO = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int DEF_STEP_W        = 16;
    localparam int DEF_PER_W         = 20;
    localparam int DEF_PULSE_CYC     = 50;
    localparam int DEF_DIR_SETUP_CYC = 10;
    localparam int DEF_IDLE_HOLD_CYC = 50_000_000;

endpackage

// File: rtl/easy_driver_axis_ctrl_if.sv
// Move-command handshake between the command source (master) and the axis sequencer (slave).
interface easy_driver_axis_ctrl_if #(
    parameter int STEP_W = 16,
    parameter int PER_W  = 20
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [STEP_W-1:0] cmd_steps;
    logic [PER_W-1:0]  cmd_period;

    modport master (output cmd_valid, output cmd_steps, output cmd_period, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_steps, input cmd_period, output cmd_ready);
endinterface

// File: rtl/easy_driver_axis_ctrl_step_timer.sv
// Down-counter shared by all timed states: load the state length minus one, expired at zero.
module easy_driver_axis_ctrl_step_timer #(
    parameter int PER_W = 20
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic             load,
    input  logic [PER_W-1:0] load_val,
    output logic             expired
);
    logic [PER_W-1:0] count;

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);
endmodule

// File: rtl/easy_driver_axis_ctrl.sv
// Single-axis EasyDriver sequencer: signed relative moves in, timed dir/step/enable out,
// absolute position tracked in steps.
module easy_driver_axis_ctrl
    import easy_driver_axis_ctrl_pkg::*;
#(
    parameter int STEP_W        = DEF_STEP_W,
    parameter int PER_W         = DEF_PER_W,
    parameter int PULSE_CYC     = DEF_PULSE_CYC,
    parameter int DIR_SETUP_CYC = DEF_DIR_SETUP_CYC,
    parameter int IDLE_HOLD_CYC = DEF_IDLE_HOLD_CYC
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset_n,
    easy_driver_axis_ctrl_if.slave cmd,
    input  logic                   abort,
    input  logic                   pos_clr,
    output logic                   busy,
    output logic                   done,
    output logic signed [31:0]     position,
    output logic                   driver_dir,
    output logic                   driver_step,
    output logic                   driver_enable_n
);
    localparam logic [PER_W-1:0] MIN_PER  = PER_W'(2 * PULSE_CYC);
    localparam logic [PER_W-1:0] HI_LOAD  = PER_W'(PULSE_CYC - 1);
    localparam logic [PER_W-1:0] LO_SUB   = PER_W'(PULSE_CYC + 1);
    localparam logic [PER_W-1:0] SET_LOAD = PER_W'(DIR_SETUP_CYC - 1);
    localparam logic [31:0]      HOLD     = 32'(IDLE_HOLD_CYC);

    state_t            state, state_nxt;
    logic              accept;
    logic              steps_zero;
    logic              rise;
    logic              abort_pend;
    logic              tmr_load;
    logic              tmr_expired;
    logic [STEP_W-1:0] remaining;
    logic [PER_W-1:0]  per;
    logic [PER_W-1:0]  tmr_val;
    logic [31:0]       idle_cnt;

    assign accept     = cmd.cmd_valid && (state == IDLE);
    assign steps_zero = (cmd.cmd_steps == '0);

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Abort only cuts SETUP/STEP_LO short; a pulse already high always runs its full width.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = steps_zero ? DONE : SETUP;
            SETUP:   if (abort) state_nxt = DONE;
                     else if (tmr_expired) state_nxt = STEP_HI;
            STEP_HI: if (tmr_expired) state_nxt = (abort || abort_pend) ? DONE : STEP_LO;
            STEP_LO: if (abort || (tmr_expired && remaining == '0)) state_nxt = DONE;
                     else if (tmr_expired) state_nxt = STEP_HI;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd.cmd_ready = (state == IDLE);
        busy          = (state != IDLE);
        done          = (state == DONE);
        driver_step   = (state == STEP_HI);
    end

    // Every state change reloads the timer with the length of the state being entered.
    always_comb begin
        tmr_load = (state_nxt != state);
        case (state_nxt)
            SETUP:   tmr_val = SET_LOAD;
            STEP_HI: tmr_val = HI_LOAD;
            STEP_LO: tmr_val = per - LO_SUB;
            default: tmr_val = '0;
        endcase
    end

    easy_driver_axis_ctrl_step_timer #(.PER_W(PER_W)) u_timer (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .load          (tmr_load),
        .load_val      (tmr_val),
        .expired       (tmr_expired)
    );

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            rise       <= 1'b0;
            remaining  <= '0;
            per        <= '0;
            driver_dir <= 1'b0;
            abort_pend <= 1'b0;
        end else begin
            rise <= (state_nxt == STEP_HI) && (state != STEP_HI);
            if (accept) begin
                driver_dir <= ~cmd.cmd_steps[STEP_W-1];
                remaining  <= cmd.cmd_steps[STEP_W-1] ? (~cmd.cmd_steps + 1'b1) : cmd.cmd_steps;
                per        <= (cmd.cmd_period < MIN_PER) ? MIN_PER : cmd.cmd_period;
            end else if (rise) begin
                remaining <= remaining - 1'b1;
            end
            if (state == IDLE) begin
                abort_pend <= 1'b0;
            end else if (abort && state == STEP_HI) begin
                abort_pend <= 1'b1;
            end
        end
    end

    // The position moves in the first high cycle of each pulse; a clear in that cycle drops the step.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            position <= '0;
        end else if (pos_clr) begin
            position <= '0;
        end else if (rise) begin
            position <= driver_dir ? position + 32'sd1 : position - 32'sd1;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            idle_cnt        <= '0;
            driver_enable_n <= 1'b1;
        end else if (accept) begin
            idle_cnt <= '0;
            if (!steps_zero) driver_enable_n <= 1'b0;
        end else if (state == IDLE) begin
            if (HOLD != 32'd0 && idle_cnt != HOLD) begin
                idle_cnt <= idle_cnt + 32'd1;
                if (idle_cnt == HOLD - 32'd1) driver_enable_n <= 1'b1;
            end
        end else begin
            idle_cnt <= '0;
        end
    end
endmodule
